// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: SEG sum bits per stage, STAGES = WIDTH/SEG, valid/ready flow control.
// Define RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = (SEG >= 1) ? (WIDTH / SEG) : 1;

    if (SEG < 1 || WIDTH < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("pipelined_ripple_adder: WIDTH must be a positive multiple of SEG, SEG >= 1");
    end

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    logic advance_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // Operand bits still to be added shrink by SEG per stage; computed sum bits grow by SEG.
    for (genvar k = 0; k < STAGES; k++) begin : stage
        localparam int AW = WIDTH - k * SEG;
        localparam int SW = (k + 1) * SEG;

        logic [AW-1:0]  a_in_s;
        logic [AW-1:0]  b_in_s;
        logic           v_in_s;
        logic           c_in_s;
        logic [SEG-1:0] seg_sum_s;
        logic           seg_cout_s;
        logic [SW-1:0]  sum_next_s;
        logic           valid_r;
        logic           carry_r;
        logic [SW-1:0]  sum_r;

        if (k == 0) begin : g_first
            assign a_in_s     = a;
            assign b_in_s     = b;
            assign v_in_s     = in_valid;
            assign c_in_s     = cin;
            assign sum_next_s = seg_sum_s;
        end else begin : g_next
            assign a_in_s     = stage[k-1].g_fwd.a_r;
            assign b_in_s     = stage[k-1].g_fwd.b_r;
            assign v_in_s     = stage[k-1].valid_r;
            assign c_in_s     = stage[k-1].carry_r;
            assign sum_next_s = {seg_sum_s, stage[k-1].sum_r};
        end

        // SEG-bit ripple of full adders over the lowest unconsumed operand bits.
        always_comb begin
            logic       c_v;
            logic [1:0] fa_v;
            c_v       = c_in_s;
            fa_v      = 2'b00;
            seg_sum_s = '0;
            for (int i = 0; i < SEG; i++) begin
                fa_v         = full_add(a_in_s[i], b_in_s[i], c_v);
                seg_sum_s[i] = fa_v[0];
                c_v          = fa_v[1];
            end
            seg_cout_s = c_v;
        end

        // Stage register: valid always follows the pipe, data only loads for real operations.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_r <= 1'b0;
                carry_r <= 1'b0;
                sum_r   <= '0;
            end else if (advance_s) begin
                valid_r <= v_in_s;
                if (v_in_s) begin
                    carry_r <= seg_cout_s;
                    sum_r   <= sum_next_s;
                end else begin
                    carry_r <= carry_r;
                    sum_r   <= sum_r;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [AW-SEG-1:0] a_r;
            logic [AW-SEG-1:0] b_r;

            // Forward the operand bits later stages still need.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance_s && v_in_s) begin
                    a_r <= a_in_s[AW-1:SEG];
                    b_r <= b_in_s[AW-1:SEG];
                end
            end
        end
    end

    assign out_valid = stage[STAGES-1].valid_r;
    assign sum       = stage[STAGES-1].sum_r;
    assign cout      = stage[STAGES-1].carry_r;

`ifdef RCA_OVF_EN
    logic ovf_r;

    // The last stage sees the operand MSBs at bit SEG-1 of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (advance_s && stage[STAGES-1].v_in_s) begin
            ovf_r <= (stage[STAGES-1].a_in_s[SEG-1] == stage[STAGES-1].b_in_s[SEG-1]) &&
                     (stage[STAGES-1].seg_sum_s[SEG-1] != stage[STAGES-1].a_in_s[SEG-1]);
        end
    end

    assign ovf = ovf_r;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder: 16/4 instance with directed vectors,
// 4/1 instance streamed exhaustively; ovf checked when RCA_OVF_EN is defined.
module tb_pipelined_ripple_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv, ir, ov, ordy, ci, co;
    logic [15:0] a, b, s;
    logic        iv4, ir4, ov4, ordy4, ci4, co4;
    logic [3:0]  a4, b4, s4;
`ifdef RCA_OVF_EN
    logic        ovf16, ovf4;
`endif

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    pipelined_ripple_adder #(.WIDTH(16), .SEG(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci),
        .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co)
`ifdef RCA_OVF_EN
        , .ovf(ovf16)
`endif
    );

    pipelined_ripple_adder #(.WIDTH(4), .SEG(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(ordy4), .sum(s4), .cout(co4)
`ifdef RCA_OVF_EN
        , .ovf(ovf4)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst && ov && ordy) begin
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected16 actual=out_valid sum=0x%0h expected=no output", s);
            end else begin
                e = q16.pop_front();
                chk("sum16", {16'h0000, s}, {16'h0000, e.sum});
                chk("cout16", {31'h0, co}, {31'h0, e.cout});
`ifdef RCA_OVF_EN
                chk("ovf16", {31'h0, ovf16}, {31'h0, e.ovf});
`endif
                if (e.lat) chk("latency16", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && ov4 && ordy4) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected4 actual=out_valid sum=0x%0h expected=no output", s4);
            end else begin
                e = q4.pop_front();
                chk("sum4", {28'h0, s4}, {16'h0000, e.sum});
                chk("cout4", {31'h0, co4}, {31'h0, e.cout});
`ifdef RCA_OVF_EN
                chk("ovf4", {31'h0, ovf4}, {31'h0, e.ovf});
`endif
                if (e.lat) chk("latency4", cyc, e.due);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input bit lat, input bit keep);
        int   n;
        exp_t e;
        a  = va;
        b  = vb;
        ci = vc;
        iv = 1'b1;
        @(negedge clk);
        n = 0;
        while (!ir && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir) begin
            checks++;
            failures++;
            $display("FAIL accept16 actual=in_ready 0 expected=in_ready 1 within 50 cycles");
            iv = 1'b0;
        end else if (keep) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            e.due  = cyc + 4;
            e.lat  = lat;
            q16.push_back(e);
        end
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q4.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d/%0d pending expected=0/0", q16.size(), q4.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int          n;
        logic [4:0]  e5;
        exp_t        e4;
        rst = 1'b1; iv = 1'b0; a = 16'h0000; b = 16'h0000; ci = 1'b0; ordy = 1'b1;
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0; ordy4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, ov}, 32'h0);
        chk("rst_sum", {16'h0000, s}, 32'h0);
        chk("rst_cout", {31'h0, co}, 32'h0);
`ifdef RCA_OVF_EN
        chk("rst_ovf", {31'h0, ovf16}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, ir}, 32'h1);
        @(posedge clk);
        #1;

        // Isolated wrap-around case with latency check.
        send16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();

        // Back-to-back directed vectors with hand-computed results.
        send16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1, 1'b1);
        send16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1);
        send16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
        send16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        send16(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        send16(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        send16(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        send16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        send16(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Backpressure: output holds for 3 cycles, then results follow in order.
        ordy = 1'b0;
        send16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b1);
        send16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach", {31'h0, ov}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_sum", {16'h0000, s}, 32'h2345);
            chk("stall_in_ready", {31'h0, ir}, 32'h0);
            chk("stall_out_valid", {31'h0, ov}, 32'h1);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        ordy = 1'b1;
        drain();

        // Reset two cycles after acceptance discards the operation.
        send16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst2", {31'h0, ir}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk("discarded_no_valid", {31'h0, ov}, 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // WIDTH=4, SEG=1: every a, b, cin streamed back to back.
        for (int i = 0; i < 512; i++) begin
            a4  = 4'(i);
            b4  = 4'(i >> 4);
            ci4 = i[8];
            iv4 = 1'b1;
            @(negedge clk);
            if (!ir4) begin
                checks++;
                failures++;
                $display("FAIL accept4 actual=in_ready 0 expected=in_ready 1 at vector %0d", i);
            end else begin
                e5      = {1'b0, a4} + {1'b0, b4} + {4'b0000, ci4};
                e4.sum  = {12'h000, e5[3:0]};
                e4.cout = e5[4];
                e4.ovf  = (a4[3] == b4[3]) && (e5[3] != a4[3]);
                e4.due  = cyc + 4;
                e4.lat  = 1'b1;
                q4.push_back(e4);
            end
            @(posedge clk);
            #1;
        end
        iv4 = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=bench completion");
        $fatal(1, "watchdog expired");
    end
endmodule
